// File: rtl/down_counter_191.sv
// ============================================================================
// Module   : down_counter_191
// Purpose  : Loadable down counter with borrow flag and one-cycle expiry pulse.
//            The DOWN_COUNTER_AUTO_RELOAD_EN macro selects periodic reload on expiry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_191 #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             CRn,
  input  logic             LDn,
  input  logic [WIDTH-1:0] D,
  input  logic             CTT,
  input  logic             CTP,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             ZP,
  output logic             RUN
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [WIDTH-1:0] r_reg, r_nxt;
  logic             zp_reg, zp_nxt;
  logic             count_en;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign count_en = CTT & CTP & LDn;

  always_ff @(posedge CP or negedge CRn) begin
    if (!CRn) begin
      state  <= ST_IDLE;
      q_reg  <= '0;
      r_reg  <= '0;
      zp_reg <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_reg  <= q_nxt;
      r_reg  <= r_nxt;
      zp_reg <= zp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    r_nxt     = r_reg;
    zp_nxt    = 1'b0;
    if (!LDn) begin
      q_nxt     = D;
      r_nxt     = D;
      state_nxt = (D != '0) ? ST_RUN : ST_HALT;
    end else if (state == ST_RUN && count_en) begin
      if (q_reg > ONE) begin
        q_nxt = q_reg - ONE;
      end else if (q_reg == ONE) begin
        zp_nxt = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        q_nxt  = r_reg;
`else
        // One-shot: R is captured but unused in this build
        q_nxt     = '0;
        state_nxt = ST_HALT;
`endif
      end
    end
  end

  assign Q   = q_reg;
  assign BO  = (q_reg == '0);
  assign ZP  = zp_reg;
  assign RUN = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_down_counter_191.sv
// Bench for down_counter_191: directed scenarios then random traffic against a
// behavioural model of remaining-ticks / armed state.
`default_nettype none

module tb_down_counter_191;

  localparam int WIDTH = 8;

  logic             CP = 1'b0;
  logic             CRn = 1'b0;
  logic             LDn = 1'b1;
  logic [WIDTH-1:0] D = '0;
  logic             CTT = 1'b0;
  logic             CTP = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             BO, ZP, RUN;

  int checks = 0;
  int failures = 0;

  // Model: remaining ticks, period, armed flag, pulse
  int m_left = 0;
  int m_period = 0;
  bit m_armed = 0;
  bit m_pulse = 0;
  int pulses;

  down_counter_191 #(.WIDTH(WIDTH)) dut (
    .CP(CP), .CRn(CRn), .LDn(LDn), .D(D), .CTT(CTT), .CTP(CTP),
    .Q(Q), .BO(BO), .ZP(ZP), .RUN(RUN)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".Q"}, 32'(Q), 32'(m_left));
    chk({tag, ".BO"}, 32'(BO), 32'(m_left == 0));
    chk({tag, ".ZP"}, 32'(ZP), 32'(m_pulse));
    chk({tag, ".RUN"}, 32'(RUN), 32'(m_armed));
  endtask

  task automatic model_edge(input bit ld_n, input int d, input bit en);
    m_pulse = 0;
    if (!ld_n) begin
      m_left = d;
      m_period = d;
      m_armed = (d != 0);
    end else if (m_armed && en) begin
      if (m_left == 1) begin
        m_pulse = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_left = m_period;
`else
        m_left = 0;
        m_armed = 0;
`endif
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic cyc(input string tag, input bit ld_n, input int d, input bit t, input bit p);
    @(negedge CP);
    LDn = ld_n;
    D   = d[WIDTH-1:0];
    CTT = t;
    CTP = p;
    @(posedge CP);
    model_edge(ld_n, d, t & p);
    #1;
    chk_model(tag);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.Q", 32'(Q), 0);
    chk("rst.BO", 32'(BO), 1);
    chk("rst.ZP", 32'(ZP), 0);
    chk("rst.RUN", 32'(RUN), 0);
    @(negedge CP);
    CRn = 1'b1;

    // Reach Q=5, then async reset mid-cycle
    cyc("ld7", 1'b0, 7, 1, 1);
    cyc("c1", 1'b1, 0, 1, 1);
    cyc("c2", 1'b1, 0, 1, 1);
    chk("pre_rst.Q", 32'(Q), 5);
    #2;
    CRn = 1'b0;
    #1;
    chk("async.Q", 32'(Q), 0);
    chk("async.BO", 32'(BO), 1);
    chk("async.ZP", 32'(ZP), 0);
    chk("async.RUN", 32'(RUN), 0);
    m_left = 0; m_period = 0; m_armed = 0; m_pulse = 0;
    @(negedge CP);
    CRn = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle", 1'b1, 0, 1, 1);
    chk("idle.Q", 32'(Q), 0);

    // One-shot / auto-reload from D=3
    cyc("ld3", 1'b0, 3, 1, 1);
    chk("ld3.Q", 32'(Q), 3);
    for (int i = 0; i < 8; i++) cyc("run3", 1'b1, 0, 1, 1);

    // D=4 for 12 enabled cycles, count pulses
    cyc("ld4", 1'b0, 4, 0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("run4", 1'b1, 0, 1, 1);
      pulses += int'(ZP);
    end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    chk("pulses4", 32'(pulses), 3);
`else
    chk("pulses4", 32'(pulses), 1);
`endif

    // Enable gating with CTP toggling
    cyc("ld5", 1'b0, 5, 1, 1);
    for (int i = 0; i < 12; i++) cyc("gate", 1'b1, 0, 1, (i % 2) == 0);

    // Load on expiry edge
    cyc("ld2", 1'b0, 2, 1, 1);
    cyc("to1", 1'b1, 0, 1, 1);
    chk("to1.Q", 32'(Q), 1);
    cyc("coll", 1'b0, 9, 1, 1);
    chk("coll.Q", 32'(Q), 9);
    chk("coll.ZP", 32'(ZP), 0);
    chk("coll.RUN", 32'(RUN), 1);

    // Zero load
    cyc("ld0", 1'b0, 0, 1, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("halt", 1'b1, 0, 1, 1);
      pulses += int'(ZP);
    end
    chk("halt.pulses", 32'(pulses), 0);
    chk("halt.RUN", 32'(RUN), 0);

    // D=1 period
    cyc("ld1", 1'b0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("d1", 1'b1, 0, 1, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit ld_n;
      int d;
      ld_n = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      cyc("rand", ld_n, d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
